rf_write_scheduler: RTL

//   Shares the register file's single write port between two requesters.
//   - Pipeline writeback (WB): fixed priority, never stalled.
//   - Multi-cycle MUL/DIV unit (MD): valid/ready handshake, buffered in a FIFO.

---
 rtl/rf_pkg.sv | 19 +
 rtl/rf_sched_fifo.sv | 46 ++++
 rtl/rf_write_scheduler.sv | 114 +++++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file write scheduler.
package rf_pkg;

    localparam int RF_AW    = 5;
    localparam int RF_DW    = 32;
    localparam int RF_NREGS = 1 << RF_AW;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_WB,
        SRC_MD
    } rf_src_t;

    typedef struct packed {
        logic [RF_AW-1:0] addr;
        logic [RF_DW-1:0] data;
    } rf_wr_t;

endpackage

// File: rtl/rf_sched_fifo.sv
// Synchronous FIFO of rf_wr_t entries with occupancy count.
// The caller guarantees no push when full and no pop when empty.
module rf_sched_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  rf_wr_t                   din,
    input  logic                     pop,
    output rf_wr_t                   dout,
    output logic [$clog2(DEPTH):0]   cnt
);

    localparam int PW = $clog2(DEPTH);

    rf_wr_t         mem [DEPTH];
    logic [PW-1:0]  wptr;
    logic [PW-1:0]  rptr;

    // Storage needs no reset: cnt alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign dout = mem[rptr];

endmodule

// File: rtl/rf_write_scheduler.sv
// Arbitrates the register-file write port between WB (priority) and the MD unit.
// Optional direct MD-to-port path when RF_SCHED_BYPASS_EN is defined.
module rf_write_scheduler
    import rf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = RF_AW,
    parameter int DW    = RF_DW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_we,
    input  logic [AW-1:0]            wb_addr,
    input  logic [DW-1:0]            wb_data,
    input  logic                     md_valid,
    output logic                     md_ready,
    input  logic [AW-1:0]            md_addr,
    input  logic [DW-1:0]            md_data,
    input  logic                     iss_valid,
    input  logic [AW-1:0]            iss_addr,
    input  logic [AW-1:0]            chk_reg1,
    input  logic [AW-1:0]            chk_reg2,
    output logic                     stall,
    output logic                     rf_we,
    output logic [AW-1:0]            rf_waddr,
    output logic [DW-1:0]            rf_wdata,
    output logic [$clog2(DEPTH):0]   fifo_cnt,
    output logic                     err_reiss
);

    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int NREGS = 1 << AW;

    logic            wb_grant, fifo_empty, md_acc, push, pop, byp;
    logic            we_d;
    rf_src_t         src_d, src_q;
    rf_wr_t          md_wr, head, wr_d;
    logic [NREGS-1:0] busy, busy_set, busy_clr;

    assign md_wr      = {md_addr, md_data};
    assign wb_grant   = wb_we && (wb_addr != '0);
    assign fifo_empty = (fifo_cnt == '0);
    assign md_ready   = (fifo_cnt < CW'(DEPTH));
    assign md_acc     = md_valid && md_ready;

`ifdef RF_SCHED_BYPASS_EN
    assign byp = !wb_grant && fifo_empty && md_acc;
`else
    assign byp = 1'b0;
`endif

    assign push = md_acc && !byp;
    assign pop  = !wb_grant && !fifo_empty;

    rf_sched_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .din  (md_wr),
        .pop  (pop),
        .dout (head),
        .cnt  (fifo_cnt)
    );

    // MD entries addressed to r0 still consume their grant slot, but write nothing.
    always_comb begin
        we_d  = 1'b0;
        src_d = SRC_NONE;
        wr_d  = md_wr;
        if (wb_grant) begin
            we_d  = 1'b1;
            src_d = SRC_WB;
            wr_d  = {wb_addr, wb_data};
        end else if (!fifo_empty) begin
            wr_d  = head;
            we_d  = (head.addr != '0);
            src_d = we_d ? SRC_MD : SRC_NONE;
        end else if (byp) begin
            wr_d  = md_wr;
            we_d  = (md_addr != '0);
            src_d = we_d ? SRC_MD : SRC_NONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            src_q    <= SRC_NONE;
        end else begin
            rf_we <= we_d;
            src_q <= src_d;
            if (we_d) {rf_waddr, rf_wdata} <= wr_d;
        end
    end

    // Clear lands on the edge the register file captures the MD data; set wins.
    assign busy_set = (iss_valid && iss_addr != '0) ? (NREGS'(1) << iss_addr) : '0;
    assign busy_clr = (rf_we && src_q == SRC_MD) ? (NREGS'(1) << rf_waddr) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy      <= '0;
            err_reiss <= 1'b0;
        end else begin
            busy      <= ((busy & ~busy_clr) | busy_set) & ~NREGS'(1);
            err_reiss <= err_reiss | (|(busy_set & busy));
        end
    end

    assign stall = busy[chk_reg1] | busy[chk_reg2];

endmodule
